// File: rtl/tap_ctrl_if.sv
// Bundles TMS and every decoded TAP output between the controller and its consumers.
// The slave side is the controller. The master side is whoever drives TMS and observes the strobes.
interface tap_ctrl_if;
   logic       TMS;
   logic [3:0] state;
   logic       TestLogicReset;
   logic       RunTestIdle;
   logic       CaptureDR;
   logic       ShiftDR;
   logic       UpdateDR;
   logic       CaptureIR;
   logic       ShiftIR;
   logic       UpdateIR;
   logic       Select;
   logic       TDO_en;

   modport slave (
      input  TMS,
      output state, TestLogicReset, RunTestIdle,
      output CaptureDR, ShiftDR, UpdateDR,
      output CaptureIR, ShiftIR, UpdateIR,
      output Select, TDO_en
   );

   modport master (
      output TMS,
      input  state, TestLogicReset, RunTestIdle,
      input  CaptureDR, ShiftDR, UpdateDR,
      input  CaptureIR, ShiftIR, UpdateIR,
      input  Select, TDO_en
   );
endinterface

// File: rtl/tap_ctrl.sv
// IEEE 1149.1 TAP controller: a 16-state Moore FSM stepped by TMS on rising TCK.
// Every output is a decode of the state register alone.
module tap_ctrl (
   input  logic           i_TCK,
   input  logic           i_TRST,
   tap_ctrl_if.slave      bus
);

   typedef enum logic [3:0] {
      ST_TLR    = 4'hF,
      ST_RTI    = 4'hC,
      ST_SELDR  = 4'h7,
      ST_CAPDR  = 4'h6,
      ST_SHDR   = 4'h2,
      ST_EX1DR  = 4'h1,
      ST_PSDR   = 4'h3,
      ST_EX2DR  = 4'h0,
      ST_UPDDR  = 4'h5,
      ST_SELIR  = 4'h4,
      ST_CAPIR  = 4'hE,
      ST_SHIR   = 4'hA,
      ST_EX1IR  = 4'h9,
      ST_PSIR   = 4'hB,
      ST_EX2IR  = 4'h8,
      ST_UPDIR  = 4'hD
   } tapState_t;

   tapState_t r_state;
   tapState_t w_nextState;
   logic      w_tms;
   logic      w_tlr, w_rti;
   logic      w_capDr, w_shDr, w_updDr;
   logic      w_capIr, w_shIr, w_updIr;
   logic      w_select;

   assign w_tms = bus.TMS;

   always_ff @(posedge i_TCK) begin
      if (i_TRST) r_state <= ST_TLR;
      else        r_state <= w_nextState;
   end

   // The next state depends on TMS. The outputs decode r_state only, so no output has a combinational path from TMS.
   always_comb begin
      w_nextState = r_state;
      w_tlr    = 1'b0;
      w_rti    = 1'b0;
      w_capDr  = 1'b0;
      w_shDr   = 1'b0;
      w_updDr  = 1'b0;
      w_capIr  = 1'b0;
      w_shIr   = 1'b0;
      w_updIr  = 1'b0;
      w_select = 1'b0;
      case (r_state)
         ST_TLR:   begin w_nextState = w_tms ? ST_TLR   : ST_RTI;   w_tlr = 1'b1; end
         ST_RTI:   begin w_nextState = w_tms ? ST_SELDR : ST_RTI;   w_rti = 1'b1; end
         ST_SELDR: w_nextState = w_tms ? ST_SELIR : ST_CAPDR;
         ST_CAPDR: begin w_nextState = w_tms ? ST_EX1DR : ST_SHDR;  w_capDr = 1'b1; end
         ST_SHDR:  begin w_nextState = w_tms ? ST_EX1DR : ST_SHDR;  w_shDr  = 1'b1; end
         ST_EX1DR: w_nextState = w_tms ? ST_UPDDR : ST_PSDR;
         ST_PSDR:  w_nextState = w_tms ? ST_EX2DR : ST_PSDR;
         ST_EX2DR: w_nextState = w_tms ? ST_UPDDR : ST_SHDR;
         ST_UPDDR: begin w_nextState = w_tms ? ST_SELDR : ST_RTI;   w_updDr = 1'b1; end
         ST_SELIR: begin w_nextState = w_tms ? ST_TLR   : ST_CAPIR; w_select = 1'b1; end
         ST_CAPIR: begin w_nextState = w_tms ? ST_EX1IR : ST_SHIR;  w_capIr = 1'b1; w_select = 1'b1; end
         ST_SHIR:  begin w_nextState = w_tms ? ST_EX1IR : ST_SHIR;  w_shIr  = 1'b1; w_select = 1'b1; end
         ST_EX1IR: begin w_nextState = w_tms ? ST_UPDIR : ST_PSIR;  w_select = 1'b1; end
         ST_PSIR:  begin w_nextState = w_tms ? ST_EX2IR : ST_PSIR;  w_select = 1'b1; end
         ST_EX2IR: begin w_nextState = w_tms ? ST_UPDIR : ST_SHIR;  w_select = 1'b1; end
         ST_UPDIR: begin w_nextState = w_tms ? ST_SELDR : ST_RTI;   w_updIr = 1'b1; w_select = 1'b1; end
         default:  w_nextState = ST_TLR;
      endcase
   end

   assign bus.state          = r_state;
   assign bus.TestLogicReset = w_tlr;
   assign bus.RunTestIdle    = w_rti;
   assign bus.CaptureDR      = w_capDr;
   assign bus.ShiftDR        = w_shDr;
   assign bus.UpdateDR       = w_updDr;
   assign bus.CaptureIR      = w_capIr;
   assign bus.ShiftIR        = w_shIr;
   assign bus.UpdateIR       = w_updIr;
   assign bus.Select         = w_select;
   assign bus.TDO_en         = w_shDr | w_shIr;

endmodule

// File: tb/tb_tap_ctrl.sv
// Self-checking bench for tap_ctrl: fixed scan sequences, escape from every state, then a random TMS/TRST soak.
// Expected values come from a transition table and state-name decodes kept in the bench.
module tb_tap_ctrl;

   logic tck  = 1'b0;
   logic trst = 1'b1;

   tap_ctrl_if bus();

   tap_ctrl dut (
      .i_TCK  (tck),
      .i_TRST (trst),
      .bus    (bus)
   );

   always #5 tck = ~tck;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [3:0] nxt [16][2];
   logic [3:0] mState = 4'hF;

   typedef struct {
      logic       trst;
      logic       tms;
      logic [3:0] expState;
   } vec_t;

   vec_t vecs[$];

   function automatic void addVec(input logic t, input logic m, input logic [3:0] s);
      vec_t v;
      v.trst = t;
      v.tms = m;
      v.expState = s;
      vecs.push_back(v);
   endfunction

   // Output bit order: TLR, RTI, CapDR, ShDR, UpdDR, CapIR, ShIR, UpdIR, Select, TDO_en.
   function automatic logic [9:0] expOut(input logic [3:0] s);
      logic [9:0] o;
      o    = '0;
      o[9] = (s == 4'hF);
      o[8] = (s == 4'hC);
      o[7] = (s == 4'h6);
      o[6] = (s == 4'h2);
      o[5] = (s == 4'h5);
      o[4] = (s == 4'hE);
      o[3] = (s == 4'hA);
      o[2] = (s == 4'hD);
      o[1] = (s inside {4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD});
      o[0] = o[6] | o[3];
      return o;
   endfunction

   function automatic logic [9:0] dutOut();
      return {bus.TestLogicReset, bus.RunTestIdle, bus.CaptureDR, bus.ShiftDR, bus.UpdateDR,
              bus.CaptureIR, bus.ShiftIR, bus.UpdateIR, bus.Select, bus.TDO_en};
   endfunction

   task automatic applyStimulus(input logic t, input logic m);
      @(negedge tck);
      trst    = t;
      bus.TMS = m;
      @(posedge tck);
      #1;
      mState = t ? 4'hF : nxt[mState][m];
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] expState);
      testsRun++;
      if (bus.state !== expState) begin
         testsFailed++;
         $display("[TB] FAIL %s state: got %h want %h", tag, bus.state, expState);
      end
      testsRun++;
      if (dutOut() !== expOut(expState)) begin
         testsFailed++;
         $display("[TB] FAIL %s outputs: got %b want %b", tag, dutOut(), expOut(expState));
      end
   endtask

   task automatic checkCount(input string tag, input int got, input int want);
      testsRun++;
      if (got != want) begin
         testsFailed++;
         $display("[TB] FAIL %s count: got %0d want %0d", tag, got, want);
      end
   endtask

   initial begin
      int nShift, nCap, nUpd, steps;
      logic [3:0] target;
      logic [0:10] seq;

      bus.TMS = 1'b0;
      nxt[4'hF] = '{4'hC, 4'hF};  nxt[4'hC] = '{4'hC, 4'h7};
      nxt[4'h7] = '{4'h6, 4'h4};  nxt[4'h6] = '{4'h2, 4'h1};
      nxt[4'h2] = '{4'h2, 4'h1};  nxt[4'h1] = '{4'h3, 4'h5};
      nxt[4'h3] = '{4'h3, 4'h0};  nxt[4'h0] = '{4'h2, 4'h5};
      nxt[4'h5] = '{4'hC, 4'h7};  nxt[4'h4] = '{4'hE, 4'hF};
      nxt[4'hE] = '{4'hA, 4'h9};  nxt[4'hA] = '{4'hA, 4'h9};
      nxt[4'h9] = '{4'hB, 4'hD};  nxt[4'hB] = '{4'hB, 4'h8};
      nxt[4'h8] = '{4'hA, 4'hD};  nxt[4'hD] = '{4'hC, 4'h7};

      addVec(1, 0, 4'hF); addVec(0, 0, 4'hC);
      addVec(0, 1, 4'h7); addVec(0, 0, 4'h6); addVec(0, 0, 4'h2); addVec(0, 0, 4'h2);
      addVec(0, 0, 4'h2); addVec(0, 0, 4'h2); addVec(0, 1, 4'h1); addVec(0, 1, 4'h5);
      addVec(0, 0, 4'hC);
      addVec(0, 1, 4'h7); addVec(0, 1, 4'h4); addVec(0, 0, 4'hE); addVec(0, 0, 4'hA);
      addVec(0, 0, 4'hA); addVec(0, 1, 4'h9); addVec(0, 1, 4'hD); addVec(0, 0, 4'hC);
      addVec(0, 1, 4'h7); addVec(0, 0, 4'h6); addVec(0, 0, 4'h2);
      addVec(0, 1, 4'h1); addVec(0, 0, 4'h3); addVec(0, 0, 4'h3); addVec(0, 1, 4'h0);
      addVec(0, 0, 4'h2);
      addVec(1, 0, 4'hF);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].trst, vecs[i].tms);
         checkOutput($sformatf("vec%0d", i), vecs[i].expState);
      end

      // A six-cycle shift dwell must give six ShiftDR cycles and single capture/update strobes.
      applyStimulus(0, 0);
      seq = 11'b100_00000_110;
      nShift = 0; nCap = 0; nUpd = 0;
      for (int i = 0; i < 11; i++) begin
         applyStimulus(0, seq[i]);
         checkOutput("dwell", mState);
         nShift += int'(bus.ShiftDR);
         nCap   += int'(bus.CaptureDR);
         nUpd   += int'(bus.UpdateDR);
      end
      checkCount("dwell ShiftDR", nShift, 6);
      checkCount("dwell CaptureDR", nCap, 1);
      checkCount("dwell UpdateDR", nUpd, 1);
      checkOutput("dwell end", 4'hC);

      for (int s = 0; s < 16; s++) begin
         target = 4'(s);
         applyStimulus(1, 0);
         steps = 0;
         while (mState != target && steps < 500) begin
            applyStimulus(0, 1'($urandom_range(0, 1)));
            checkOutput("walk", mState);
            steps++;
         end
         checkCount($sformatf("reach %h", target), int'(mState == target), 1);
         for (int k = 0; k < 5; k++) applyStimulus(0, 1);
         checkOutput($sformatf("escape from %h", target), 4'hF);
         applyStimulus(0, 1);
         checkOutput($sformatf("hold after %h", target), 4'hF);
      end

      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)));
         checkOutput("rand", mState);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/tap_ctrl.md
# tap_ctrl

IEEE 1149.1 TAP controller: a 16-state Moore FSM clocked by TCK and steered by TMS. It sits directly upstream of the bypass register and the other data/instruction registers. It produces the decoded CaptureDR/ShiftDR/UpdateDR and IR-equivalent strobes those registers consume, plus the TDO mux select and enable.

## Interface
- No parameters.
- TCK  input  1  JTAG clock; all state updates on rising edge.
- TRST  input  1  reset; synchronous, active-high; sampled on rising TCK.
- TMS  input  1  test mode select; sampled on rising TCK.
- state  output  4  current TAP state encoding, for debug and verification.
- TestLogicReset  output  1  high while in Test-Logic-Reset.
- RunTestIdle  output  1  high while in Run-Test/Idle.
- CaptureDR, ShiftDR, UpdateDR  output  1 each  high while in the named DR state.
- CaptureIR, ShiftIR, UpdateIR  output  1 each  high while in the named IR state.
- Select  output  1  TDO mux select: 1 = IR path, 0 = DR path.
- TDO_en  output  1  TDO drive enable; high only in Shift-DR or Shift-IR.

## Operation
- State encoding (hex), fixed:
  - TLR=F, RTI=C
  - SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PsDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PsIR=B, Ex2IR=8, UpdIR=D
- Transitions are given as "TMS=0 next / TMS=1 next":
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - CapDR: ShDR / Ex1DR
  - ShDR: ShDR / Ex1DR
  - Ex1DR: PsDR / UpdDR
  - PsDR: PsDR / Ex2DR
  - Ex2DR: ShDR / UpdDR
  - UpdDR: RTI / SelDR
  - SelIR: CapIR / TLR
  - IR branch mirrors the DR branch (CapIR through UpdIR), with UpdIR: RTI / SelDR.
- All outputs are pure combinational decodes of the state register. No output depends on TMS combinationally.
- Select = 1 in SelIR, CapIR, ShIR, Ex1IR, PsIR, Ex2IR, UpdIR; 0 in all other states.
- Exactly one of the eight named state strobes is high in any state that has a strobe. In Select/Exit/Pause states all eight strobes are 0.
- Any state reaches TLR after at most 5 consecutive rising edges with TMS=1.
- Unreachable encodings: none. All 16 codes are legal.

## Timing
- Reset: TRST=1 at a rising TCK puts state=F at that edge, regardless of TMS.
- Reset values: TestLogicReset=1, Select=0, TDO_en=0, all other strobes 0.
- TRST has priority over TMS. Asserting it mid-shift aborts the shift; ShiftDR/ShiftIR fall after that edge.
- Latency: the state changes one TCK edge after TMS is sampled. Strobes are valid for the whole cycle following that edge.
- Consumers sample the strobes on the next rising TCK. In a ShDR dwell of N cycles, ShiftDR is high for exactly N rising edges, so downstream registers shift N bits.
- CaptureDR is high for exactly one cycle per DR scan. UpdateDR is high for exactly one cycle, then state goes to RTI or SelDR.
- Pause states hold with all strobes low. Ex2 → Sh resumes shifting with no capture.

## Test plan
- Reset: TRST=1 for 1 edge with TMS=0 → state=F, TestLogicReset=1, every other output 0. Release TRST, TMS=0 → next edge state=C, RunTestIdle=1.
- DR scan: from RTI apply TMS sequence 1,0,0,0,0,0,1,1,0 → states 7,6,2,2,2,2,1,5,C. CaptureDR high 1 cycle, ShiftDR high 4 cycles, TDO_en matches ShiftDR, UpdateDR high 1 cycle, Select=0 throughout.
- IR scan: from RTI apply TMS 1,1,0,0,0,1,1,0 → states 7,4,E,A,A,9,D,C. CaptureIR, ShiftIR (2 cycles) and UpdateIR strobe correctly; Select=1 from state 4 through D.
- Pause/resume: in ShDR apply TMS 1,0,0,1,0 → states 1,3,3,0,2. ShiftDR is 0 during 1/3/0 and high again in 2; CaptureDR is not reasserted.
- Escape: from each of the 16 states, apply five TMS=1 edges → state=F at or before edge 5 and remains F.
- Reset mid-operation: TRST=1 while in ShDR with TMS=0 → state=F on that edge, ShiftDR and TDO_en low in the following cycle.
